prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter RAMSIZE, 64, number of byte addresses in program RAM (2..256).
REQ-002 SHALL have parameter TIMEOUT, 1024, idle-cycle limit used only when PROG_LOADER_TIMEOUT_EN is defined.
REQ-003 SHALL use clock clk, rising-edge, and reset reset, asynchronous, active-high.
REQ-004 Ports, in this order:
- clk  in  1  clock
- reset  in  1  async reset, active-high
- in_data  in  8  loader byte stream
- in_valid  in  1  in_data valid
- in_ready  out  1  loader can accept a byte
- ram_we  out  1  program RAM write strobe
- ram_addr  out  8  program RAM byte address
- ram_wdata  out  8  program RAM write data
- core_run  out  1  level; releases the downstream processor core
- load_done  out  1  one-cycle pulse on successful load
- load_error  out  1  level; frame rejected

Function
REQ-005 SHALL count a byte as accepted only in a cycle where in_valid && in_ready.
REQ-006 SHALL parse frame: SYNC (0xA5), LEN (1..RAMSIZE), LEN payload bytes, CHK (8-bit modulo-256 sum of payload).
REQ-007 SHALL implement states IDLE, LEN, DATA, CHK, FILL, DONE, ERROR.
REQ-008 IDLE: in_ready=1; accepted 0xA5 -> LEN; any other byte discarded.
REQ-009 LEN: accepted 0 or >RAMSIZE -> ERROR; otherwise latch LEN, clear sum and address counter, -> DATA.
REQ-010 DATA: each accepted byte SHALL be written to RAM at address 0,1,2,... and added to sum; after the LEN-th byte -> CHK.
REQ-011 RAM writes SHALL be registered: ram_we=1 with ram_addr/ram_wdata valid the cycle after acceptance; ram_we=0 otherwise.
REQ-012 CHK: accepted byte equal to sum -> FILL (or DONE if LEN==RAMSIZE); mismatch -> ERROR.
REQ-013 FILL: in_ready=0; SHALL write 0x00 to addresses LEN..RAMSIZE-1, one per cycle, ram_we continuous; after address RAMSIZE-1 -> DONE.
REQ-014 DONE: in_ready=0, core_run=1; load_done SHALL pulse exactly in the first DONE cycle; DONE SHALL be left only by reset.
REQ-015 ERROR: load_error=1, in_ready=1, core_run=0; accepted 0xA5 -> LEN and clears load_error; other bytes discarded.
REQ-016 core_run SHALL be 0 in every state except DONE; a partially written RAM SHALL never be released.
REQ-017 Address counter SHALL be 8 bits; with RAMSIZE=256 the final fill SHALL end at 255 without wrap-induced extra writes.
REQ-018 A 0xA5 byte inside DATA or CHK SHALL be treated as payload/checksum, not as a resync.

Reset
REQ-019 On reset: state IDLE, in_ready=0 during reset then 1, ram_we=0, ram_addr=0, ram_wdata=0, core_run=0, load_done=0, load_error=0, sum=0.
REQ-020 Reset asserted mid-frame or mid-fill SHALL abort immediately with no further RAM writes; RAM contents are not cleared.

Configuration
REQ-021 With PROG_LOADER_TIMEOUT_EN defined: in LEN, DATA or CHK, TIMEOUT consecutive cycles without an accepted byte SHALL force ERROR; counter resets on each accepted byte.
REQ-022 Without PROG_LOADER_TIMEOUT_EN: no timeout counter exists; loader waits indefinitely.

Structure
REQ-023 Shared package proc_pkg SHALL hold SYNC_BYTE (0xA5), default RAMSIZE, and the loader state enum typedef.
REQ-024 Single flat module; no sub-module (checksum is one adder).

Verification
REQ-025 Frame A5 04 02 00 10 00 12 -> writes addr0..3 = 02,00,10,00; zeros at 4..63; load_done pulse; core_run=1.
REQ-026 Frame A5 02 05 07 00 -> checksum mismatch (expect 0C) -> load_error=1, core_run=0; then A5 01 33 33 -> success, load_error=0.
REQ-027 A5 00, and A5 41 with RAMSIZE=64 -> ERROR, no ram_we.
REQ-028 Reset asserted after 2 payload bytes of a 4-byte frame -> all outputs at reset values next cycle, no further writes.
REQ-029 With PROG_LOADER_TIMEOUT_EN, TIMEOUT=16: A5 03 11 then in_valid=0 for 16 cycles -> load_error=1; without macro, state stays DATA.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the program loader: sync byte, default RAM size and
// the loader state encoding.
package proc_pkg;

    localparam logic [7:0] SYNC_BYTE       = 8'hA5;
    localparam int         RAMSIZE_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHK   = 3'd3,
        ST_FILL  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } loader_state_t;

endpackage

// File: rtl/prog_loader.sv
// Frame-based program loader: SYNC, LEN, payload, CHK -> program RAM, zero fill,
// then releases the core. Define PROG_LOADER_TIMEOUT_EN for the idle timeout.
module prog_loader
    import proc_pkg::*;
#(
    parameter int RAMSIZE = RAMSIZE_DEFAULT,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ram_we,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       core_run,
    output logic       load_done,
    output logic       load_error
);

    localparam logic [8:0] RAMSIZE_W = 9'(RAMSIZE);
    localparam logic [7:0] LAST_ADDR = 8'(RAMSIZE - 1);

    loader_state_t state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    sum_q, sum_d;
    logic          ram_we_q, ram_we_d;
    logic [7:0]    ram_addr_q, ram_addr_d;
    logic [7:0]    ram_wdata_q, ram_wdata_d;
    logic          load_done_q, load_done_d;
    logic          ready_state;
    logic          accept;
    logic          timeout_hit;

    always_comb begin
        case (state_q)
            ST_IDLE, ST_LEN, ST_DATA, ST_CHK, ST_ERROR: ready_state = 1'b1;
            default:                                    ready_state = 1'b0;
        endcase
    end

    // Held low while reset is asserted so no byte is consumed during reset.
    assign in_ready = ready_state & ~reset;
    assign accept   = in_valid & in_ready;

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] idle_q, idle_d;

    always_comb begin
        idle_d      = '0;
        timeout_hit = 1'b0;
        if ((state_q == ST_LEN || state_q == ST_DATA || state_q == ST_CHK) && !accept) begin
            if (idle_q == TW'(TIMEOUT - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && in_data == SYNC_BYTE) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (accept) begin
                    if (in_data == 8'd0 || {1'b0, in_data} > RAMSIZE_W) begin
                        state_d = ST_ERROR;
                    end else begin
                        len_d   = in_data;
                        sum_d   = 8'd0;
                        cnt_d   = 8'd0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = cnt_q;
                    ram_wdata_d = in_data;
                    sum_d       = sum_q + in_data;
                    cnt_d       = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (in_data != sum_q) begin
                        state_d = ST_ERROR;
                    end else if ({1'b0, len_q} == RAMSIZE_W) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                // cnt_q arrives here equal to LEN; it stops at the last address
                // rather than wrapping, so a 256-byte RAM ends cleanly at 255.
                ram_we_d    = 1'b1;
                ram_addr_d  = cnt_q;
                ram_wdata_d = 8'h00;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERROR: begin
                if (accept && in_data == SYNC_BYTE) state_d = ST_LEN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (timeout_hit) state_d = ST_ERROR;
        load_done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            sum_q       <= 8'd0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 8'd0;
            ram_wdata_q <= 8'd0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            load_done_q <= load_done_d;
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign load_done  = load_done_q;
    assign core_run   = (state_q == ST_DONE);
    assign load_error = (state_q == ST_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized frames
// checked against a frame-level model of expected RAM writes and outcome.
module tb_prog_loader;

    localparam int RAMSIZE = 64;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       core_run;
    logic       load_done;
    logic       load_error;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [7:0] frame_q[$];
    logic [7:0] exp_addr[$];
    logic [7:0] exp_data[$];
    logic [7:0] obs_addr[$];
    logic [7:0] obs_data[$];

    prog_loader #(.RAMSIZE(RAMSIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .core_run   (core_run),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_we) begin
            obs_addr.push_back(ram_addr);
            obs_data.push_back(ram_wdata);
        end
        if (load_done) done_cnt++;
    end

    task automatic clear_logs();
        exp_addr.delete(); exp_data.delete();
        obs_addr.delete(); obs_data.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_logs();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_byte timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        foreach (frame_q[i]) send_byte(frame_q[i], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
    endtask

    // Model of a well-formed frame: payload at 0..len-1, then zeros up to the top
    // of RAM when the checksum is good.
    task automatic build_frame(input int len, input bit corrupt, input int garbage);
        logic [7:0] sum;
        logic [7:0] b;
        frame_q.delete();
        repeat (garbage) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            frame_q.push_back(b);
        end
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(len));
        sum = 8'h00;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            frame_q.push_back(b);
            exp_addr.push_back(8'(i));
            exp_data.push_back(b);
            sum = sum + b;
        end
        if (corrupt) begin
            frame_q.push_back(sum + 8'($urandom_range(1, 255)));
        end else begin
            frame_q.push_back(sum);
            for (int i = len; i < RAMSIZE; i++) begin
                exp_addr.push_back(8'(i));
                exp_data.push_back(8'h00);
            end
        end
    endtask

    task automatic check_writes(input string name);
        checks++;
        if (obs_addr.size() !== exp_addr.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, obs_addr.size(), exp_addr.size());
        end else begin
            foreach (exp_addr[i]) begin
                checks++;
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL %s write[%0d]: got %02h=%02h required %02h=%02h",
                             name, i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
                end
            end
        end
    endtask

    task automatic finish_ok(input string name);
        int n = 0;
        while (!core_run && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (core_run !== 1'b1 || load_error !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s done_state: core_run=%0b load_error=%0b in_ready=%0b required 1 0 0",
                     name, core_run, load_error, in_ready);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s load_done_pulses: got %0d required 1", name, done_cnt);
        end
        check_writes(name);
        $display("frame %s: ok, %0d writes", name, obs_addr.size());
    endtask

    task automatic finish_err(input string name);
        repeat (4) @(negedge clk);
        checks++;
        if (load_error !== 1'b1 || core_run !== 1'b0 || in_ready !== 1'b1 || done_cnt !== 0) begin
            errors++;
            $display("FAIL %s error_state: load_error=%0b core_run=%0b in_ready=%0b done=%0d required 1 0 1 0",
                     name, load_error, core_run, in_ready, done_cnt);
        end
        check_writes(name);
        $display("frame %s: rejected, %0d writes", name, obs_addr.size());
    endtask

    task automatic check_reset_outputs(input string name, input logic ready_exp);
        checks++;
        if (in_ready !== ready_exp || ram_we !== 1'b0 || ram_addr !== 8'h00 || ram_wdata !== 8'h00 ||
            core_run !== 1'b0 || load_done !== 1'b0 || load_error !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs: rdy=%0b we=%0b addr=%02h wd=%02h run=%0b done=%0b err=%0b required rdy=%0b rest 0",
                     name, in_ready, ram_we, ram_addr, ram_wdata, core_run, load_done, load_error, ready_exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_reset_outputs("reset_held", 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_released", 1'b1);
        clear_logs();
        $display("reset: checked");
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic test_vector_a();
        frame_q = '{8'hA5, 8'h04, 8'h02, 8'h00, 8'h10, 8'h00, 8'h12};
        push_exp(8'd0, 8'h02); push_exp(8'd1, 8'h00); push_exp(8'd2, 8'h10); push_exp(8'd3, 8'h00);
        for (int i = 4; i < RAMSIZE; i++) push_exp(8'(i), 8'h00);
        send_frame(0);
        finish_ok("vector_a");
        do_reset();
    endtask

    task automatic test_checksum_error();
        frame_q = '{8'hA5, 8'h02, 8'h05, 8'h07, 8'h00};
        push_exp(8'd0, 8'h05); push_exp(8'd1, 8'h07);
        send_frame(0);
        finish_err("bad_checksum");
        clear_logs();
        frame_q = '{8'hA5, 8'h01, 8'h33, 8'h33};
        push_exp(8'd0, 8'h33);
        for (int i = 1; i < RAMSIZE; i++) push_exp(8'(i), 8'h00);
        send_frame(0);
        finish_ok("recover_after_error");
        do_reset();
    endtask

    task automatic test_bad_len();
        frame_q = '{8'hA5, 8'h00};
        send_frame(0);
        finish_err("len_zero");
        frame_q = '{8'hA5, 8'h41};
        send_frame(0);
        finish_err("len_too_big");
        do_reset();
    endtask

    task automatic test_sync_in_payload();
        frame_q = '{8'hA5, 8'h03, 8'hA5, 8'hA5, 8'h01, 8'h4B};
        push_exp(8'd0, 8'hA5); push_exp(8'd1, 8'hA5); push_exp(8'd2, 8'h01);
        for (int i = 3; i < RAMSIZE; i++) push_exp(8'(i), 8'h00);
        send_frame(1);
        finish_ok("sync_in_payload");
        do_reset();
    endtask

    task automatic test_full_length();
        build_frame(RAMSIZE, 1'b0, 0);
        send_frame(0);
        finish_ok("full_length");
        do_reset();
    endtask

    task automatic test_reset_midframe();
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset = 1'b1;
        push_exp(8'd0, 8'h11);
        @(negedge clk);
        check_reset_outputs("midframe_reset", 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_outputs("after_midframe_reset", 1'b1);
        check_writes("midframe_reset");
        $display("midframe reset: %0d writes", obs_addr.size());
        clear_logs();
    endtask

    task automatic test_random();
        int len;
        bit corrupt;
        for (int t = 0; t < 10; t++) begin
            len = (t == 0) ? 1 : $urandom_range(1, RAMSIZE);
            corrupt = ($urandom_range(0, 2) == 0);
            build_frame(len, corrupt, $urandom_range(0, 3));
            send_frame(2);
            if (corrupt) finish_err($sformatf("random%0d_len%0d", t, len));
            else         finish_ok($sformatf("random%0d_len%0d", t, len));
            do_reset();
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hA5, 0);
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        push_exp(8'd0, 8'h11);
        repeat (TIMEOUT + 4) @(negedge clk);
`ifdef PROG_LOADER_TIMEOUT_EN
        finish_err("timeout");
        clear_logs();
        frame_q = '{8'hA5, 8'h01, 8'h33, 8'h33};
        push_exp(8'd0, 8'h33);
        for (int i = 1; i < RAMSIZE; i++) push_exp(8'(i), 8'h00);
        send_frame(0);
        finish_ok("after_timeout");
`else
        checks++;
        if (load_error !== 1'b0 || in_ready !== 1'b1 || core_run !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_wait: load_error=%0b in_ready=%0b core_run=%0b required 0 1 0",
                     load_error, in_ready, core_run);
        end
        frame_q = '{8'h22, 8'h33, 8'h66};
        push_exp(8'd1, 8'h22); push_exp(8'd2, 8'h33);
        for (int i = 3; i < RAMSIZE; i++) push_exp(8'(i), 8'h00);
        send_frame(0);
        finish_ok("long_wait_resume");
`endif
        do_reset();
    endtask

    initial begin
        test_reset();
        test_vector_a();
        test_checksum_error();
        test_bad_len();
        test_sync_in_payload();
        test_full_length();
        test_reset_midframe();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
